// File: rtl/exchange_node.sv
// Per-replica ordering store: double-banked city ordering plus total, exchanged with
// chain neighbours by streaming the active bank while rebuilding the shadow bank.
package exchange_pkg;
  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;

  typedef logic [31:0] total_data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LAST   = 2'd2
  } node_state_t;

  typedef struct packed {
    node_state_t state;
    logic        bank_sel;
    logic [7:0]  node_id;
  } node_dbg_t;
endpackage

module exchange_node
  import exchange_pkg::*;
#(
  parameter int id       = 0,
  parameter int city_num = 64,
  parameter int data_w   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  exchange_command_t           exchange_ex,
  input  logic [data_w-1:0]           prev_word,
  input  logic [data_w-1:0]           folw_word,
  input  total_data_t                 prev_total,
  input  total_data_t                 folw_total,
  output logic [data_w-1:0]           out_word,
  output total_data_t                 out_total,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  input  logic [$clog2(city_num)-1:0] rd_addr,
  output logic [data_w-1:0]           rd_data,
  input  logic                        wr_en,
  input  logic [$clog2(city_num)-1:0] wr_addr,
  input  logic [data_w-1:0]           wr_data,
  input  logic                        total_we,
  input  total_data_t                 total_in,
  output node_dbg_t                   dbg
);
  localparam int aw = $clog2(city_num);
  localparam int depth = 1 << (aw + 1);
  localparam logic [aw-1:0] last_addr = aw'(city_num - 1);

  // Command interface: exchange_ex is valid every cycle and there is no ready; a
  // non-NOP seen while busy is dropped and recorded in the sticky overrun flag.
  node_state_t       state, state_nx;
  exchange_command_t cmd;
  logic              bank_sel;
  logic [aw-1:0]     cnt;
  logic              idle;
  logic              accept;

  // Entry index is {bank, address}.
  logic [data_w-1:0] mem [depth];
  logic              mem_we;
  logic [aw:0]       mem_waddr;
  logic [data_w-1:0] mem_wdata;
  logic [data_w-1:0] stream_word;

  assign idle   = (state == ST_IDLE);
  assign accept = idle && (exchange_ex != NOP);
  assign busy   = !idle;
  assign done   = (state == ST_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_STREAM;
      ST_STREAM: if (cnt == last_addr) state_nx = ST_LAST;
      ST_LAST:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd       <= NOP;
      cnt       <= '0;
      bank_sel  <= 1'b0;
      out_word  <= '0;
      out_total <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        cmd <= exchange_ex;
        cnt <= '0;
        // Total is taken from the named source on the command edge itself.
        case (exchange_ex)
          PREV:    out_total <= prev_total;
          FOLW:    out_total <= folw_total;
          default: out_total <= out_total;
        endcase
      end else if (idle && total_we) begin
        out_total <= total_in;
      end
      if (state == ST_STREAM) begin
        cnt      <= cnt + 1'b1;
        out_word <= mem[{bank_sel, cnt}];
      end
      if (state == ST_LAST) bank_sel <= ~bank_sel;
      if (busy && (exchange_ex != NOP)) overrun <= 1'b1;
    end
  end

  always_comb begin
    case (cmd)
      PREV:    stream_word = prev_word;
      FOLW:    stream_word = folw_word;
      default: stream_word = out_word;
    endcase
  end

  // One write port: optimizer writes the active bank when idle, the exchange
  // rebuilds the shadow bank one word behind the read pointer.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {bank_sel, wr_addr};
    mem_wdata = wr_data;
    if (idle) mem_we = wr_en;
    if ((state == ST_STREAM) && (cnt != '0)) begin
      mem_we    = 1'b1;
      mem_waddr = {~bank_sel, cnt - 1'b1};
      mem_wdata = stream_word;
    end
    if (state == ST_LAST) begin
      mem_we    = 1'b1;
      mem_waddr = {~bank_sel, last_addr};
      mem_wdata = stream_word;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{bank_sel, rd_addr}];
  end

  always_comb begin
    dbg          = '0;
    dbg.state    = state;
    dbg.bank_sel = bank_sel;
    dbg.node_id  = 8'(id);
  end
endmodule

// File: doc/exchange_node.md
# exchange_node

Per-replica ordering store that consumes the `exchange_ex` command stream issued by each replica's exchange test and carries out the data movement it names. Each instance holds its replica's city ordering in a double-banked RAM plus its `total_data_t` distance, and sits in the replica chain between its neighbours. On a non-NOP command it streams its active bank out to both neighbours while rebuilding its shadow bank from the selected source (self, prev or folw). It then swaps banks.

## Interface
- `id`, 0, replica index (informational; end replicas get SELF/NOP from upstream)
- `city_num`, 64, ordering length in words (≥2)
- `data_w`, 8, city index width
- `clk` input 1 clock
- `reset` input 1 asynchronous, active-high reset
- `exchange_ex` input exchange_command_t command (NOP/SELF/PREV/FOLW), valid every cycle
- `prev_word` input data_w neighbour (id-1) streamed word
- `folw_word` input data_w neighbour (id+1) streamed word
- `prev_total` input total_data_t neighbour (id-1) total
- `folw_total` input total_data_t neighbour (id+1) total
- `out_word` output data_w this node's streamed word (to both neighbours)
- `out_total` output total_data_t this node's current total
- `busy` output 1 exchange in progress
- `done` output 1 one-cycle pulse on bank swap
- `overrun` output 1 sticky: non-NOP command arrived while busy
- `rd_addr` input $clog2(city_num) optimizer read address
- `rd_data` output data_w active-bank word, 1-cycle latency
- `wr_en` input 1 optimizer write strobe (active bank)
- `wr_addr` input $clog2(city_num) write address
- `wr_data` input data_w write data
- `total_we` input 1 optimizer load of total
- `total_in` input total_data_t total to load

## Operation
- States: IDLE, STREAM, LAST.
- IDLE, `exchange_ex`≠NOP: latch command as `cmd`; go to STREAM; set rd counter=0.
- On that same edge, `out_total` is loaded from the source that `cmd` names:
  - SELF: unchanged.
  - PREV: `prev_total`.
  - FOLW: `folw_total`.
- STREAM: each cycle read active bank at counter, and the counter increments. `out_word` is the registered RAM output.
- From the second STREAM cycle, write the shadow bank at counter−1. The written word is selected by `cmd`:
  - SELF: `out_word`.
  - PREV: `prev_word`.
  - FOLW: `folw_word`.
- After the read at counter=city_num−1, go to LAST.
- LAST: write the final word at city_num−1, toggle bank select, pulse `done`, return to IDLE.
- Neighbours receive their commands on the same cycle, so all streams are cycle-aligned. No handshake exists between nodes.
- Total ordering: words leave a node in address order 0..city_num−1.
- Optimizer port (`wr_en`, `total_we`):
  - Honoured only in IDLE; ignored while busy.
  - Writes the active bank and takes effect for reads the next cycle.
  - `total_we` in the same cycle as an accepted command: the command wins.
- `rd_data` always reads the active bank. The active bank is never written during an exchange, so reads stay consistent until the swap.
- Non-NOP while busy: ignored, `overrun` set. Only reset clears `overrun`.
- NOP while busy: no effect.

## Timing
- Command sampled at edge T0. `busy`=1 from T0+1 through the LAST cycle (city_num+1 cycles).
- `out_word` for address k is valid in cycle T0+2+k.
- The shadow write of address k occurs at the edge ending cycle T0+2+k.
- `done`=1 during the LAST cycle. The bank swap is visible to `rd_data` for reads issued in the cycle after LAST.
- A new command is accepted in the first cycle with `busy`=0, i.e. back-to-back exchanges have a 1-cycle gap minimum.
- `out_total` changes at T0. Neighbours must therefore sample totals in the same cycle as the command, before the update.
- Reset (async, anytime incl. mid-stream):
  - Outputs: `busy`=0, `done`=0, `overrun`=0, `out_word`=0, `out_total`=0, `rd_data`=0.
  - State: IDLE, bank select=0, counter=0.
  - RAM contents are not cleared. A partially rebuilt shadow bank is discarded.

## Test plan
- Load bank 0 with words 0..63 and total 0x100 via the optimizer port. Issue SELF. Expect `done` at T0+65 and identical readback of 0..63 with total 0x100.
- Chain of three nodes, middle node loaded with 63−k. Issue PREV to node 2 only (others SELF). Expect node 2 to read back 63−k and to take the middle node's total. The middle node is unchanged.
- FOLW to node 0 with node 1 holding 0xA5 everywhere. Expect node 0 to read 0xA5 at all 64 addresses after the swap, and to read its old data at every address before `done`.
- Issue FOLW at T0, then PREV at T0+10. Expect `overrun`=1 and the first exchange to complete unchanged. A command at the first non-busy cycle is accepted.
- Assert reset at T0+30 of an exchange. Expect all outputs 0 asynchronously, bank select 0, and old bank-0 contents readable. `busy` stays low until the next command.
- `wr_en` and `total_we` during busy are ignored. `total_we` coincident with an accepted PREV yields `prev_total`.
